// File: rtl/dram_sweep_ctrl_if.sv
// Sweep handshake bundle between a DRAM test initiator and dram_sweep_ctrl.
// master: drives start/rnw/wdat, watches stop/ready/rdat.
// slave : the responder; drives stop/ready/rdat.
interface dram_sweep_ctrl_if #(
  parameter int DATA_W = 16
) ();
  logic              start;
  logic              rnw;
  logic              stop;
  logic              ready;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] rdat;

  modport master (output start, rnw, wdat, input stop, ready, rdat);
  modport slave  (input start, rnw, wdat, output stop, ready, rdat);
endinterface

// File: rtl/dram_sweep_ctrl.sv
// Purpose: responder for start/rnw/stop/ready linear sweeps over a 16-bit dual-bank async DRAM,
//          including power-up init and periodic CBR refresh hidden from the initiator.
// Latency: 6 clocks per word (ready on the 6th), +5 per interleaved refresh; stop returns 1 clock after the last ready.
// Backpressure: none on the word stream; start is honoured only while stop=1, otherwise ignored.
// Ports: clk, rst_n (async, active-low); sweep (slave: start/rnw/wdat in, stop/ready/rdat out);
//        DRAM_DQ/MA/RAS0_N/RAS1_N/LCAS_N/UCAS_N/WE_N pins, all driven from registers.
module dram_sweep_ctrl #(
  parameter int DRAM_DATA_SIZE = 16,
  parameter int DRAM_MA_SIZE   = 10,
  parameter int SWEEP_LOG2     = 21,
  parameter int INIT_WAIT      = 5000,
  parameter int INIT_REFRESHES = 8,
  parameter int REFRESH_PERIOD = 390
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dram_sweep_ctrl_if.slave          sweep,
  inout  wire  [DRAM_DATA_SIZE-1:0] DRAM_DQ,
  output logic [DRAM_MA_SIZE-1:0]   DRAM_MA,
  output logic                      DRAM_RAS0_N,
  output logic                      DRAM_RAS1_N,
  output logic                      DRAM_LCAS_N,
  output logic                      DRAM_UCAS_N,
  output logic                      DRAM_WE_N
);

  localparam int AW  = 2*DRAM_MA_SIZE + 1;          // {bank, row, col}
  localparam int SW  = SWEEP_LOG2;
  localparam int IW  = $clog2(INIT_WAIT + 1);
  localparam int RFW = $clog2(INIT_REFRESHES + 1);
  localparam int RW  = $clog2(REFRESH_PERIOD + 1);

  typedef enum logic [2:0] {S_INIT_IDLE, S_INIT_REF, S_IDLE, S_ACCESS, S_REF} state_t;

  state_t                    state;
  logic [2:0]                phase;
  logic [IW-1:0]             init_cnt;
  logic [RFW-1:0]            ref_left;
  logic [SW-1:0]             addr;
  logic                      last_q;
  logic                      rnw_q;
  logic                      in_sweep;
  logic [RW-1:0]             rt_cnt;
  logic                      rt_run;
  logic                      ref_pend;
  logic                      dq_oe;
  logic [DRAM_DATA_SIZE-1:0] dq_out;

  logic [AW-1:0]             full_addr;
  logic                      bank;
  logic [DRAM_MA_SIZE-1:0]   row;
  logic [DRAM_MA_SIZE-1:0]   col;

  // Address bits above SWEEP_LOG2 are tied to zero by the zero-extension.
  assign full_addr = AW'(addr);
  assign bank      = full_addr[AW-1];
  assign row       = full_addr[2*DRAM_MA_SIZE-1:DRAM_MA_SIZE];
  assign col       = full_addr[DRAM_MA_SIZE-1:0];

  assign DRAM_DQ = dq_oe ? dq_out : {DRAM_DATA_SIZE{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT_IDLE;
      phase       <= 3'd0;
      init_cnt    <= '0;
      ref_left    <= '0;
      addr        <= '0;
      last_q      <= 1'b0;
      rnw_q       <= 1'b0;
      in_sweep    <= 1'b0;
      rt_cnt      <= '0;
      rt_run      <= 1'b0;
      ref_pend    <= 1'b0;
      dq_oe       <= 1'b0;
      dq_out      <= '0;
      DRAM_MA     <= '0;
      DRAM_RAS0_N <= 1'b1;
      DRAM_RAS1_N <= 1'b1;
      DRAM_LCAS_N <= 1'b1;
      DRAM_UCAS_N <= 1'b1;
      DRAM_WE_N   <= 1'b1;
      sweep.stop  <= 1'b0;
      sweep.ready <= 1'b0;
      sweep.rdat  <= '0;
    end else begin
      sweep.ready <= 1'b0;

      // Pins for a phase are written on the edge that enters it.
      case (state)
        S_INIT_IDLE: begin
          if (init_cnt == IW'(INIT_WAIT - 1)) begin
            state       <= S_INIT_REF;
            phase       <= 3'd0;
            ref_left    <= RFW'(INIT_REFRESHES - 1);
            DRAM_LCAS_N <= 1'b0;
            DRAM_UCAS_N <= 1'b0;
          end else begin
            init_cnt <= init_cnt + IW'(1);
          end
        end

        S_IDLE: begin
          // start wins over a pending refresh: it is accepted, and the refresh runs first.
          if (sweep.start || ref_pend) begin
            sweep.stop <= 1'b0;
            phase      <= 3'd0;
            if (sweep.start) begin
              rnw_q    <= sweep.rnw;
              addr     <= '0;
              in_sweep <= 1'b1;
            end
            if (ref_pend) begin
              state       <= S_REF;
              ref_pend    <= 1'b0;
              DRAM_LCAS_N <= 1'b0;
              DRAM_UCAS_N <= 1'b0;
            end else begin
              state   <= S_ACCESS;
              DRAM_MA <= '0;                        // row of address 0
            end
          end
        end

        S_ACCESS: begin
          case (phase)
            3'd0: begin
              if (bank) DRAM_RAS1_N <= 1'b0;
              else      DRAM_RAS0_N <= 1'b0;
              phase <= 3'd1;
            end
            3'd1: begin
              DRAM_MA   <= col;
              DRAM_WE_N <= rnw_q;
              dq_oe     <= ~rnw_q;
              dq_out    <= sweep.wdat;
              phase     <= 3'd2;
            end
            3'd2: begin
              DRAM_LCAS_N <= 1'b0;
              DRAM_UCAS_N <= 1'b0;
              phase       <= 3'd3;
            end
            3'd3: phase <= 3'd4;
            3'd4: begin
              if (rnw_q) sweep.rdat <= DRAM_DQ;
              DRAM_RAS0_N <= 1'b1;
              DRAM_RAS1_N <= 1'b1;
              DRAM_LCAS_N <= 1'b1;
              DRAM_UCAS_N <= 1'b1;
              DRAM_WE_N   <= 1'b1;
              dq_oe       <= 1'b0;
              sweep.ready <= 1'b1;
              // Advance during A5 so the next row is ready for A0; wrap to 0 is natural.
              last_q      <= (addr == '1);
              addr        <= addr + SW'(1);
              phase       <= 3'd5;
            end
            default: begin
              phase <= 3'd0;
              if (last_q) begin
                state      <= S_IDLE;
                in_sweep   <= 1'b0;
                sweep.stop <= 1'b1;
              end else if (ref_pend) begin
                state       <= S_REF;
                ref_pend    <= 1'b0;
                DRAM_LCAS_N <= 1'b0;
                DRAM_UCAS_N <= 1'b0;
              end else begin
                DRAM_MA <= row;
              end
            end
          endcase
        end

        // CBR: CAS low, RAS low, hold 2, all high.
        S_INIT_REF, S_REF: begin
          case (phase)
            3'd0: begin
              DRAM_RAS0_N <= 1'b0;
              DRAM_RAS1_N <= 1'b0;
              phase       <= 3'd1;
            end
            3'd1, 3'd2: phase <= phase + 3'd1;
            3'd3: begin
              DRAM_RAS0_N <= 1'b1;
              DRAM_RAS1_N <= 1'b1;
              DRAM_LCAS_N <= 1'b1;
              DRAM_UCAS_N <= 1'b1;
              phase       <= 3'd4;
            end
            default: begin
              phase <= 3'd0;
              if (state == S_INIT_REF && ref_left != '0) begin
                ref_left    <= ref_left - RFW'(1);
                DRAM_LCAS_N <= 1'b0;
                DRAM_UCAS_N <= 1'b0;
              end else if (state == S_INIT_REF || !in_sweep) begin
                state      <= S_IDLE;
                sweep.stop <= 1'b1;
                rt_run     <= 1'b1;
              end else begin
                state   <= S_ACCESS;
                DRAM_MA <= row;
              end
            end
          endcase
        end

        default: state <= S_INIT_IDLE;
      endcase

      // Placed after the FSM so a new request is never lost to a same-cycle clear.
      if (rt_run) begin
        if (rt_cnt == RW'(REFRESH_PERIOD - 1)) begin
          rt_cnt   <= '0;
          ref_pend <= 1'b1;
        end else begin
          rt_cnt <= rt_cnt + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_sweep_ctrl.sv
module tb_dram_sweep_ctrl;
  localparam int DW = 16;
  localparam int MW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dram_sweep_ctrl_if #(.DATA_W(DW)) sif ();

  wire  [DW-1:0] dq;
  logic [MW-1:0] ma;
  logic          ras0_n, ras1_n, lcas_n, ucas_n, we_n;
  logic          model_oe  = 1'b0;
  logic [DW-1:0] model_dat = '0;
  assign dq = model_oe ? model_dat : {DW{1'bz}};

  dram_sweep_ctrl #(
    .DRAM_DATA_SIZE(DW), .DRAM_MA_SIZE(MW), .SWEEP_LOG2(4),
    .INIT_WAIT(20), .INIT_REFRESHES(8), .REFRESH_PERIOD(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sweep(sif.slave),
    .DRAM_DQ(dq), .DRAM_MA(ma),
    .DRAM_RAS0_N(ras0_n), .DRAM_RAS1_N(ras1_n),
    .DRAM_LCAS_N(lcas_n), .DRAM_UCAS_N(ucas_n), .DRAM_WE_N(we_n)
  );

  typedef struct packed { logic [31:0] addr; logic [15:0] dat; } wr_t;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, ready_total = 0, ready_base = 0, last_ready_cyc = 0;
  int refs = 0, refs_since = 0, ras_opens = 0, we_bad = 0;
  logic [15:0] wr_base = 16'h1000;
  bit sweep_rnw = 1'b0, sweep_act = 1'b0;
  logic [15:0] mem [int];
  wr_t         wr_q [$];
  logic [15:0] rd_q [$];

  logic          prev_cas = 1'b1, prev_ras0 = 1'b1, prev_ras1 = 1'b1;
  logic          acc_bank = 1'b0;
  logic [MW-1:0] acc_row = '0;

  assign sif.wdat = wr_base + 16'(ready_total - ready_base);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // DRAM model, scoreboard pops and pin-protocol monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    int key;
    wr_t e;
    logic [15:0] r;
    if (!rst_n) begin
      model_oe  = 1'b0;
      prev_cas  = 1'b1;
      prev_ras0 = 1'b1;
      prev_ras1 = 1'b1;
      ras_opens = ready_total;
    end else begin
      if (sweep_act && sweep_rnw && !we_n) we_bad++;

      if (prev_cas && !lcas_n) begin
        if (ras0_n && ras1_n) begin
          check_eq("cbr_between_words", 32'(ras_opens - ready_total), 32'd0);
        end else begin
          key = int'({acc_bank, acc_row, ma});
          if (!we_n) begin
            mem[key] = dq;
            check_eq("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
              e = wr_q.pop_front();
              check_eq("wr_addr", 32'(key), e.addr);
              check_eq("wr_dat", 32'(dq), 32'(e.dat));
            end
          end else begin
            model_oe  = 1'b1;
            model_dat = mem.exists(key) ? mem[key] : 16'hDEAD;
          end
        end
      end
      if (!prev_cas && lcas_n) model_oe = 1'b0;

      if ((prev_ras0 && !ras0_n) || (prev_ras1 && !ras1_n)) begin
        if (!lcas_n) begin
          refs++;
          refs_since++;
          check_eq("cbr_both_ras", 32'({ras0_n, ras1_n, ucas_n}), 32'd0);
        end else begin
          ras_opens++;
          acc_bank = ras0_n;
          acc_row  = ma;
        end
      end

      if (sif.ready) begin
        if (ready_total != ready_base)
          check_eq("ready_gap", 32'(cyc - last_ready_cyc), 32'(6 + 5*refs_since));
        last_ready_cyc = cyc;
        refs_since     = 0;
        if (sweep_rnw) begin
          check_eq("rd_expected", 32'(rd_q.size() != 0), 32'd1);
          if (rd_q.size() != 0) begin
            r = rd_q.pop_front();
            check_eq("rdat", 32'(sif.rdat), 32'(r));
          end
        end
        ready_total++;
      end

      prev_cas  = lcas_n;
      prev_ras0 = ras0_n;
      prev_ras1 = ras1_n;
    end
  end

  task automatic wait_init(input bit poke);
    int n;
    int refs0;
    refs0 = refs;
    for (n = 1; n <= 400; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (poke && n == 10) begin
        sif.start = 1'b1;
        sif.rnw   = 1'b1;
      end else begin
        sif.start = 1'b0;
      end
      if (sif.stop) break;
    end
    sif.start = 1'b0;
    check_eq("init_stop_cycles", 32'(n), 32'd60);
    check_eq("init_cbr_count", 32'(refs - refs0), 32'd8);
  endtask

  task automatic kick(input bit r, input logic [15:0] base);
    for (int n = 0; n < 200 && !sif.stop; n++) @(negedge clk);
    check_eq("idle_before_start", 32'(sif.stop), 32'd1);
    sweep_rnw  = r;
    wr_base    = base;
    ready_base = ready_total;
    we_bad     = 0;
    for (int i = 0; i < 16; i++) begin
      if (r) rd_q.push_back(base + 16'(i));
      else   wr_q.push_back('{addr: 32'(i), dat: base + 16'(i)});
    end
    sif.rnw   = r;
    sif.start = 1'b1;
    sweep_act = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  task automatic finish_sweep(input bit poke);
    for (int n = 0; n < 2000 && !sif.stop; n++) begin
      @(negedge clk);
      if (poke && n == 40) begin
        sif.start = 1'b1;
        sif.rnw   = ~sweep_rnw;
      end else begin
        sif.start = 1'b0;
      end
    end
    sif.start = 1'b0;
    sweep_act = 1'b0;
    check_eq("sweep_done", 32'(sif.stop), 32'd1);
    check_eq("word_count", 32'(ready_total - ready_base), 32'd16);
    check_eq("stop_after_last_ready", 32'(cyc - last_ready_cyc), 32'd1);
    check_eq("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check_eq("rd_q_drained", 32'(rd_q.size()), 32'd0);
    if (sweep_rnw) check_eq("we_high_in_read", 32'(we_bad), 32'd0);
  endtask

  initial begin
    int keep;
    int n;
    sif.start = 1'b0;
    sif.rnw   = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pins", 32'({ras0_n, ras1_n, lcas_n, ucas_n, we_n}), 32'h1F);
    check_eq("rst_ma", 32'(ma), 32'd0);
    check_eq("rst_stop", 32'(sif.stop), 32'd0);
    check_eq("rst_ready", 32'(sif.ready), 32'd0);
    check_eq("rst_rdat", 32'(sif.rdat), 32'd0);
    rst_n = 1'b1;
    wait_init(1'b1);
    check_eq("no_ready_in_init", 32'(ready_total), 32'd0);

    kick(1'b0, 16'h1000);
    finish_sweep(1'b1);
    kick(1'b1, 16'h1000);
    finish_sweep(1'b1);

    // Reset in A3 of word 5 of a write sweep.
    kick(1'b0, 16'h2000);
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (ready_total - ready_base == 5 && !lcas_n) break;
    end
    check_eq("reached_word5_a3", 32'(ready_total - ready_base), 32'd5);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_pins", 32'({ras0_n, ras1_n, lcas_n, ucas_n, we_n}), 32'h1F);
    check_eq("midrst_stop", 32'(sif.stop), 32'd0);
    check_eq("midrst_ready", 32'(sif.ready), 32'd0);
    sweep_act = 1'b0;
    keep = ready_total;
    repeat (3) @(negedge clk);
    wr_q.delete();
    rd_q.delete();
    rst_n = 1'b1;
    wait_init(1'b0);
    check_eq("no_ready_after_reset", 32'(ready_total), 32'(keep));

    kick(1'b0, 16'h3000);
    finish_sweep(1'b0);
    kick(1'b1, 16'h3000);
    finish_sweep(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
